// File: rtl/dbc_pkg.sv
// dbc_pkg: shared state encoding and width/limit helpers for the debouncer bank
package dbc_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_ZERO        = 2'd0;
  localparam state_t S_ZERO_TO_ONE = 2'd1;
  localparam state_t S_ONE         = 2'd2;
  localparam state_t S_ONE_TO_ZERO = 2'd3;
  // counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  // stable window in cycles
  function automatic int dbc_limit(input int clk_freq, input int hz);
    return clk_freq / hz;
  endfunction
endpackage

// File: rtl/dbc_if.sv
// dbc_if: debouncer bank pin bundle
// signal_i raw inputs; signal_o debounced levels; rise_o/fall_o edge pulses; repeat_o auto-repeat pulses
interface dbc_if #(parameter int CHANNELS = 4);
  logic [CHANNELS-1:0] signal_i;
  logic [CHANNELS-1:0] signal_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic [CHANNELS-1:0] repeat_o;
  modport master (output signal_i, input signal_o, rise_o, fall_o, repeat_o);
  modport slave (input signal_i, output signal_o, rise_o, fall_o, repeat_o);
endinterface

// File: rtl/dbc_chan.sv
// dbc_chan: one debounce channel (synchroniser, 4-state FSM, stable-window timer, optional auto-repeat)
// clk/rst (async, active-high); sig_i raw input; sig_o level; rise_o/fall_o/repeat_o one-cycle pulses
// Auto-repeat is built only when DBC_REPEAT_EN is defined.
module dbc_chan import dbc_pkg::*; #(
  parameter int   LIMIT         = 10,
  parameter int   REPEAT_CYCLES = 20,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);
  localparam int TW = cnt_w(LIMIT);
  localparam state_t S_INIT = INIT ? S_ONE : S_ZERO;
  if (REPEAT_CYCLES < 2) begin : g_bad_rep
    $error("dbc_chan: REPEAT_CYCLES must be >= 2");
  end
  logic sync1, sync2, expire, to_one, to_zero, in_trans;
  state_t state, state_n;
  logic [TW-1:0] timer;
  // a revert of sync2 takes priority over timer expiry, so the window restarts cleanly
  always_comb begin
    expire   = timer == TW'(LIMIT - 1);
    in_trans = state == S_ZERO_TO_ONE || state == S_ONE_TO_ZERO;
    state_n  = state == S_ZERO        ? (sync2 ? S_ZERO_TO_ONE : S_ZERO) :
               state == S_ZERO_TO_ONE ? (!sync2 ? S_ZERO : expire ? S_ONE : S_ZERO_TO_ONE) :
               state == S_ONE         ? (sync2 ? S_ONE : S_ONE_TO_ZERO) :
                                        (sync2 ? S_ONE : expire ? S_ZERO : S_ONE_TO_ZERO);
    to_one   = state == S_ZERO_TO_ONE && state_n == S_ONE;
    to_zero  = state == S_ONE_TO_ZERO && state_n == S_ZERO;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1  <= INIT;
      sync2  <= INIT;
      state  <= S_INIT;
      timer  <= '0;
      sig_o  <= INIT;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1  <= sig_i;
      sync2  <= sync1;
      state  <= state_n;
      timer  <= (in_trans && state_n == state) ? timer + 1'b1 : '0;
      sig_o  <= state_n == S_ONE || state_n == S_ONE_TO_ZERO;
      rise_o <= to_one;
      fall_o <= to_zero;
    end
`ifdef DBC_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYCLES);
  logic [RW-1:0] rcnt;
  logic held, rwrap;
  // held excludes the rise edge (state still S_ZERO_TO_ONE) and the fall edge
  always_comb begin
    held  = (state == S_ONE || state == S_ONE_TO_ZERO) && !to_zero;
    rwrap = rcnt == RW'(REPEAT_CYCLES - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rcnt     <= '0;
      repeat_o <= 1'b0;
    end else begin
      rcnt     <= (!held || rwrap) ? '0 : rcnt + 1'b1;
      repeat_o <= held && rwrap;
    end
`else
  assign repeat_o = 1'b0;
`endif
endmodule

// File: rtl/dbc_bank.sv
// dbc_bank: CHANNELS independent debouncers behind a dbc_if slave port
// clk; rst async active-high; bus: signal_i in, signal_o/rise_o/fall_o/repeat_o out
// Optional feature macro: DBC_REPEAT_EN (auto-repeat). The bus CHANNELS must equal this CHANNELS.
module dbc_bank import dbc_pkg::*; #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CLK_FREQ      = 100000000,
  parameter int                  DEBOUNCE_HZ   = 1000,
  parameter logic [CHANNELS-1:0] INIT          = '0,
  parameter int                  REPEAT_CYCLES = 25000000
) (
  input logic clk,
  input logic rst,
  dbc_if.slave bus
);
  localparam int LIMIT = dbc_limit(CLK_FREQ, DEBOUNCE_HZ);
  if (CHANNELS < 1) begin : g_bad_ch
    $error("dbc_bank: CHANNELS must be >= 1");
  end
  if (LIMIT < 2) begin : g_bad_lim
    $error("dbc_bank: CLK_FREQ/DEBOUNCE_HZ must be >= 2");
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dbc_chan #(
      .LIMIT(LIMIT),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .INIT(INIT[c])
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .sig_i(bus.signal_i[c]),
      .sig_o(bus.signal_o[c]),
      .rise_o(bus.rise_o[c]),
      .fall_o(bus.fall_o[c]),
      .repeat_o(bus.repeat_o[c])
    );
  end
endmodule

// File: tb/tb_dbc_bank.sv
// tb_dbc_bank: random + directed stimulus against a run-length reference model with a scoreboard queue
module tb_dbc_bank;
  localparam int CH = 4, L = 10, R = 20;
  localparam logic [3:0] INIT = 4'b0101;
`ifdef DBC_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  typedef struct packed {logic [3:0] lvl, rise, fall, rep;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  dbc_if #(.CHANNELS(CH)) bus();
  dbc_bank #(.CHANNELS(CH), .CLK_FREQ(1000), .DEBOUNCE_HZ(100), .INIT(INIT), .REPEAT_CYCLES(R))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t obs;
  int checks = 0, errors = 0;
  logic [3:0] m_s1, m_s2, m_out, cur;
  int m_run[CH], m_h[CH];
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask
  function automatic void m_reset();
    m_s1 = INIT; m_s2 = INIT; m_out = INIT;
    for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_h[c] = 0; end
  endfunction
  // output flips once the synchronised input has disagreed with it on L+1 consecutive edges
  function automatic exp_t m_edge(input logic [3:0] v);
    exp_t e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = (m_s2[c] != m_out[c]) ? m_run[c] + 1 : 0;
      if (m_run[c] == L + 1) begin
        m_run[c] = 0;
        m_out[c] = ~m_out[c];
        e.rise[c] = m_out[c];
        e.fall[c] = ~m_out[c];
        m_h[c] = 0;
      end else if (m_out[c]) begin
        m_h[c]++;
        if (REP && m_h[c] == R) begin e.rep[c] = 1'b1; m_h[c] = 0; end
      end else m_h[c] = 0;
    end
    m_s2 = m_s1;
    m_s1 = v;
    e.lvl = m_out;
    return e;
  endfunction
  task automatic step(input logic [3:0] v, input logic r = 1'b0);
    @(negedge clk);
    obs = {bus.signal_o, bus.rise_o, bus.fall_o, bus.repeat_o};
    cur = v;
    bus.signal_i = v;
    if (r) begin
      rst = 1'b1;
      m_reset();
      q.push_back({INIT, 12'h000});
      #1;
      chk("async_rst_lvl", bus.signal_o, INIT);
      chk("async_rst_pulse", bus.rise_o | bus.fall_o | bus.repeat_o, 4'b0);
    end else begin
      rst = 1'b0;
      q.push_back(m_edge(v));
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("signal_o", bus.signal_o, e.lvl);
      chk("rise_o", bus.rise_o, e.rise);
      chk("fall_o", bus.fall_o, e.fall);
      chk("repeat_o", bus.repeat_o, e.rep);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] acc, v;
    int n;
    bus.signal_i = INIT;
    cur = INIT;
    m_reset();
    step(INIT, 1'b1);
    step(INIT, 1'b1);
    acc = '0;
    repeat (50) begin step(INIT); acc |= obs.rise | obs.fall; end
    chk("idle_no_edges", acc, 4'b0);
    repeat (15) step(4'b0100);
    step(4'b0101);
    for (int k = 1; k <= 14; k++) begin
      step(4'b0101);
      if (k == 12) chk("press_early", {obs.lvl[0], obs.rise[0]}, 4'b0);
      if (k == 13) chk("press_at_12", {obs.lvl[0], obs.rise[0]}, 4'b0011);
      if (k == 14) chk("press_one_cycle", {3'b0, obs.rise[0]}, 4'b0);
    end
    acc = '0;
    for (int k = 0; k < 100; k++) begin
      v = cur;
      v[1] = (k % 12) < 9;
      step(v);
      acc |= {2'b0, obs.rise[1] | obs.fall[1], obs.lvl[1]};
    end
    chk("bounce_reject", acc, 4'b0);
    n = 0;
    v = cur;
    v[1] = 1'b1;
    repeat (20) begin step(v); n += obs.rise[1]; end
    chk("bounce_then_hold", 4'(n), 4'd1);
    v = cur;
    v[3:2] = 2'b10;
    repeat (15) step(v);
    v[3:2] = 2'b01;
    step(v);
    for (int k = 1; k <= 13; k++) begin
      step(v);
      if (k == 12) chk("simul_early", {2'b0, obs.rise[2], obs.fall[3]}, 4'b0);
      if (k == 13) chk("simul_same_cycle", {2'b0, obs.rise[2], obs.fall[3]}, 4'b0011);
    end
    v = cur;
    v[0] = ~v[0];
    repeat (10) step(v);
    step(INIT, 1'b1);
    acc = '0;
    repeat (30) begin step(INIT); acc |= obs.rise | obs.fall; end
    chk("midop_rst_no_pulse", acc, 4'b0);
    repeat (15) step(4'b0100);
    n = 0;
    repeat (88) begin step(4'b0101); n += obs.rep[0]; end
    chk("repeat_count_hold", 4'(n), REP ? 4'd3 : 4'd0);
    repeat (15) step(4'b0100);
    n = 0;
    repeat (30) begin step(4'b0100); n += obs.rep[0]; end
    chk("repeat_after_fall", 4'(n), 4'd0);
    for (int k = 0; k < 1500; k++) begin
      v = cur;
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 9) == 0) v[c] = ~v[c];
      step(v, $urandom_range(0, 399) == 0);
    end
    step(cur);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 4'(q.size()), 4'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
